// File: rtl/multu.sv
// -----------------------------------------------------------------------------
// multu -- sequential shift-add unsigned multiplier (32 x 32 bits).
//
// Processes one multiplier bit per clock, LSB first. A result appears exactly
// 32 rising edges after the start edge.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-high; forces IDLE and clears all state
//   a          : unsigned multiplicand, sampled only at the start edge
//   b          : unsigned multiplier, sampled only at the start edge
//   doMult     : start request, level-sampled in IDLE and DONE, ignored in BUSY
//   out        : low 32 bits of a*b (registered, held until next completion)
//   mult_done  : result-valid flag (registered), drops at the next start edge
//   out_hi     : high 32 bits of a*b, present only with MULTU_HI_OUT_EN
//
// Configuration macro
//   MULTU_HI_OUT_EN : when defined, adds out_hi and keeps a 64-bit
//                     accumulator. When undefined, only the low 32 product
//                     bits are accumulated (upper bits never reach out).
// -----------------------------------------------------------------------------
module multu (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        doMult,
   output logic [31:0] out,
`ifdef MULTU_HI_OUT_EN
   output logic [31:0] out_hi,
`endif
   output logic        mult_done
);

`ifdef MULTU_HI_OUT_EN
   localparam int ACC_W = 64;
`else
   // Carries out of bit 31 can never influence out, so they are not kept.
   localparam int ACC_W = 32;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   // Multiplicand pre-shifted by the iteration index, so each step adds it
   // directly instead of using a barrel shifter indexed by the count.
   logic [ACC_W-1:0] mcand_reg;
   // Multiplier shifted right each step; bit 0 is always the current bit.
   logic [31:0]      mplier_reg;
   logic [ACC_W-1:0] acc_reg;
   logic [4:0]       count_reg;
   logic [ACC_W-1:0] acc_next;

   // Accumulator value including the step performed at this edge; used both
   // to update the accumulator and to load the result on the final step.
   always_comb begin
      acc_next = acc_reg;
      if (mplier_reg[0]) begin
         acc_next = acc_reg + mcand_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
         out        <= '0;
`ifdef MULTU_HI_OUT_EN
         out_hi     <= '0;
`endif
         mult_done  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               // Explicit compare so an unknown doMult does not start.
               if (doMult == 1'b1) begin
                  mcand_reg  <= ACC_W'(a);
                  mplier_reg <= b;
                  acc_reg    <= '0;
                  count_reg  <= '0;
                  mult_done  <= 1'b0;
                  state_reg  <= BUSY;
               end
            end

            BUSY: begin
               acc_reg    <= acc_next;
               mcand_reg  <= {mcand_reg[ACC_W-2:0], 1'b0};
               mplier_reg <= {1'b0, mplier_reg[31:1]};
               count_reg  <= count_reg + 5'd1;
               // Index 31 is the 32nd BUSY edge: publish the full product.
               if (count_reg == 5'd31) begin
                  out       <= acc_next[31:0];
`ifdef MULTU_HI_OUT_EN
                  out_hi    <= acc_next[63:32];
`endif
                  mult_done <= 1'b1;
                  state_reg <= DONE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multu.sv
// -----------------------------------------------------------------------------
// tb_multu -- self-checking bench for multu.
// A table of directed operand pairs runs first, followed by corner sequences
// (request during BUSY, reset mid-operation) and random operands. Expected
// products come from plain 64-bit arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_multu;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic        do_mult;
   logic [31:0] out_w;
   logic        mult_done;
`ifdef MULTU_HI_OUT_EN
   logic [31:0] out_hi_w;
`endif

   int checks = 0;
   int errors = 0;

   // Bench's own record of what out should currently hold.
   logic [31:0] last_lo;
   logic [31:0] last_hi;

   multu dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .doMult    (do_mult),
      .out       (out_w),
`ifdef MULTU_HI_OUT_EN
      .out_hi    (out_hi_w),
`endif
      .mult_done (mult_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [63:0] prod;
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one operation. inject_cycle > 0 drives a second request (3*3)
   // during that BUSY cycle, which must be ignored.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [63:0] prod, input string name,
                         input int inject_cycle);
      int  n;
      bit  hold_ok;
      bit  done;
      @(negedge clk);
      a       = ta;
      b       = tb_v;
      do_mult = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_drop"}, {63'b0, mult_done}, 64'd0);
      do_mult = 1'b0;
      // Operands change after the start edge; the result must not care.
      a = $urandom;
      b = $urandom;
      n       = 0;
      hold_ok = 1'b1;
      done    = 1'b0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         do_mult = 1'b0;
         if (mult_done) done = 1'b1;
         else if (out_w !== last_lo) hold_ok = 1'b0;
         if (n == inject_cycle) begin
            a       = 32'd3;
            b       = 32'd3;
            do_mult = 1'b1;
         end
      end
      do_mult = 1'b0;
      chk({name, "_latency"}, 64'(n), 64'd32);
      chk({name, "_busy_hold"}, {63'b0, hold_ok}, 64'd1);
      chk({name, "_out"}, {32'b0, out_w}, {32'b0, prod[31:0]});
`ifdef MULTU_HI_OUT_EN
      chk({name, "_out_hi"}, {32'b0, out_hi_w}, {32'b0, prod[63:32]});
`endif
      last_lo = prod[31:0];
      last_hi = prod[63:32];
      $display("op %s: a=0x%08h b=0x%08h out=0x%08h latency=%0d", name, ta, tb_v, out_w, n);
   endtask

   vec_t vecs[6];

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{32'd2,          32'd5,          64'h0000_0000_0000_000A, "two_x_five"};
      vecs[1] = '{32'd6,          32'd7,          64'd42,                  "back_to_back"};
      vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, "max_x_max"};
      vecs[3] = '{32'd0,          32'h1234_5678,  64'd0,                   "zero_a"};
      vecs[4] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, "overflow"};
      vecs[5] = '{32'h8000_0001,  32'd1,          64'h0000_0000_8000_0001, "times_one"};

      a       = '0;
      b       = '0;
      do_mult = 1'b0;
      reset   = 1'b1;
      last_lo = '0;
      last_hi = '0;
      #12;
      chk("reset_out", {32'b0, out_w}, 64'd0);
      chk("reset_done", {63'b0, mult_done}, 64'd0);
      @(negedge clk);
      reset   = 1'b0;
      do_mult = 1'bx;
      // Unknown request must not start; a start would finish within 40 edges.
      repeat (40) @(posedge clk);
      #1;
      chk("x_no_start", {63'b0, mult_done}, 64'd0);
      chk("idle_out", {32'b0, out_w}, 64'd0);
      do_mult = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].name, 0);
         // Result and flag hold while idle in DONE.
         repeat (3) @(posedge clk);
         #1;
         chk({vecs[i].name, "_held_done"}, {63'b0, mult_done}, 64'd1);
         chk({vecs[i].name, "_held_out"}, {32'b0, out_w}, {32'b0, last_lo});
      end

      // Second request mid-operation is ignored.
      run_op(32'd7, 32'd9, 64'd63, "ignore_busy_req", 10);
      @(posedge clk);
      #1;
      chk("ignore_busy_req_no_restart", {63'b0, mult_done}, 64'd1);

      // Reset mid-operation aborts with nothing visible.
      @(negedge clk);
      a       = 32'd1234;
      b       = 32'd5678;
      do_mult = 1'b1;
      @(negedge clk);
      do_mult = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_out", {32'b0, out_w}, 64'd0);
      chk("abort_done", {63'b0, mult_done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      last_lo = '0;
      last_hi = '0;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_completion", {63'b0, mult_done}, 64'd0);
      chk("abort_out_after", {32'b0, out_w}, 64'd0);
      $display("op abort: reset at cycle 15, out=0x%08h done=%0b", out_w, mult_done);

      // Random operands against plain 64-bit arithmetic.
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 0) rb = rb & 32'h0000_00FF;
         run_op(ra, rb, {32'b0, ra} * {32'b0, rb}, $sformatf("rand%0d", i), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
